game_screen_sequencer: RTL
==========================

GAME_SCREEN_SEQUENCER -- requirements
Module: game_screen_sequencer

Interface
REQ-001 Parameter INIT_LIVES, default 3, SHALL set the lives loaded at game start (legal 1..7).
REQ-002 Parameter HOLD_FRAMES, default 120, SHALL set the frames GAMEOVER is held before restart is accepted (legal 0..1023).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port resetN, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port startOfFrame, input, 1, SHALL be a one-cycle pulse per video frame.
REQ-006 Port startKey, input, 1, SHALL be a level key input; only its rising edge is used.
REQ-007 Port pauseKey, input, 1, SHALL be a level key input; rising edge used only when PAUSE_EN is defined, otherwise ignored.
REQ-008 Port playerHit, input, 1, SHALL be a one-cycle pulse per player hit.
REQ-009 Port selector, output, 2, SHALL drive the background mux: 0 welcome, 1 play, 2 game over; value 3 never driven.
REQ-010 Port lives, output, 3, SHALL give remaining lives.
REQ-011 Port gameRunning, output, 1, SHALL be high only in state PLAY.
REQ-012 Port newGame, output, 1, SHALL pulse one cycle when a game starts.

Function
REQ-013 States WELCOME, PLAY, GAMEOVER (plus PAUSE under PAUSE_EN), one registered state vector.
REQ-014 Key edges: edge = key AND NOT key_d, key_d registered each cycle; key_d reset to 1 so a key held through reset produces no edge.
REQ-015 WELCOME + startKey edge -> PLAY next cycle; lives loaded with INIT_LIVES; newGame high that same next cycle only.
REQ-016 PLAY + playerHit with lives>1 -> lives decremented by 1, stay PLAY.
REQ-017 PLAY + playerHit with lives==1 -> GAMEOVER, lives=0, hold counter (10 bit) loaded with HOLD_FRAMES.
REQ-018 GAMEOVER: hold counter decrements by 1 per startOfFrame, saturating at 0.
REQ-019 GAMEOVER + startKey edge with counter==0 -> WELCOME; edges while counter!=0 ignored and not queued; HOLD_FRAMES=0 accepts restart on first edge.
REQ-020 playerHit outside PLAY ignored; startKey edge in PLAY/PAUSE ignored.
REQ-021 selector, gameRunning, lives decoded from registers only: update exactly one clock after the causing input cycle, no combinational input-to-output path.
REQ-022 lives never underflows; held at 0 in GAMEOVER and WELCOME re-entry until next game load.

Reset
REQ-023 resetN low SHALL immediately (asynchronously) force state WELCOME, selector=0, lives=0, gameRunning=0, newGame=0, hold counter=0, key_d registers=1.
REQ-024 Reset asserted mid-game or mid-hold SHALL abandon the operation with no residual state after release.

Configuration
REQ-025 Macro PAUSE_SCREEN_EN defined: pauseKey edge in PLAY -> PAUSE; pauseKey edge in PAUSE -> PLAY; in PAUSE selector=1, gameRunning=0, playerHit ignored, lives held.
REQ-026 PLAY with playerHit and pauseKey edge same cycle: hit processed first; if it empties lives GAMEOVER wins, else PAUSE entered with decremented lives.
REQ-027 Macro PAUSE_SCREEN_EN undefined: no PAUSE state or pause logic; pauseKey unconnected internally.

Verification
REQ-028 Reset with startKey held high, release -> no transition; selector=0, lives=0 until key released and pressed again.
REQ-029 WELCOME, startKey edge -> next cycle selector=1, lives=3, gameRunning=1, newGame high exactly 1 cycle.
REQ-030 PLAY, three playerHit pulses -> lives 2,1 then selector=2, lives=0, gameRunning=0.
REQ-031 GAMEOVER with HOLD_FRAMES=4: startKey edge after 3 frames ignored; edge after 4th startOfFrame -> selector=0.
REQ-032 PAUSE_SCREEN_EN defined, lives=1: playerHit + pauseKey edge same cycle -> GAMEOVER (selector=2), not PAUSE.
REQ-033 resetN pulsed low mid-PLAY with lives=2 -> outputs immediately selector=0, lives=0, gameRunning=0.

Source files
------------

// File: rtl/game_screen_sequencer.sv
// Screen sequencer for a simple game: welcome -> play -> game over, with a lives counter and a restart hold-off.
// Optional pause screen is compiled in when PAUSE_SCREEN_EN is defined.
module game_screen_sequencer #(
  parameter int INIT_LIVES  = 3,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       playerHit,
  output logic [1:0] selector,
  output logic [2:0] lives,
  output logic       gameRunning,
  output logic       newGame
);

`ifdef PAUSE_SCREEN_EN
  typedef enum logic [1:0] {WELCOME = 2'd0, PLAY = 2'd1, GAMEOVER = 2'd2, PAUSE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {WELCOME = 2'd0, PLAY = 2'd1, GAMEOVER = 2'd2} state_t;
`endif

  state_t     state_reg, state_next;
  logic [2:0] lives_reg, lives_next;
  logic [9:0] hold_reg, hold_next;
  logic       new_game_reg, new_game_next;
  logic       start_d_reg;
  logic       start_edge;

  // Key history resets to 1 so a key held through reset never looks like a press.
  assign start_edge = startKey & ~start_d_reg;

`ifdef PAUSE_SCREEN_EN
  logic pause_d_reg;
  logic pause_edge;
  assign pause_edge = pauseKey & ~pause_d_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) pause_d_reg <= 1'b1;
    else         pause_d_reg <= pauseKey;
  end
`else
  wire unused_pausekey = pauseKey;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= WELCOME;
      lives_reg    <= 3'd0;
      hold_reg     <= 10'd0;
      new_game_reg <= 1'b0;
      start_d_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      lives_reg    <= lives_next;
      hold_reg     <= hold_next;
      new_game_reg <= new_game_next;
      start_d_reg  <= startKey;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lives_next    = lives_reg;
    hold_next     = hold_reg;
    new_game_next = 1'b0;
    case (state_reg)
      WELCOME: begin
        if (start_edge) begin
          state_next    = PLAY;
          lives_next    = 3'(INIT_LIVES);
          new_game_next = 1'b1;
        end
      end
      PLAY: begin
        if (playerHit) begin
          if (lives_reg > 3'd1) begin
            lives_next = lives_reg - 3'd1;
          end else begin
            state_next = GAMEOVER;
            lives_next = 3'd0;
            hold_next  = 10'(HOLD_FRAMES);
          end
        end
`ifdef PAUSE_SCREEN_EN
        // The hit is resolved first; a fatal hit beats a simultaneous pause.
        if (pause_edge && !(playerHit && lives_reg <= 3'd1))
          state_next = PAUSE;
      end
      PAUSE: begin
        if (pause_edge)
          state_next = PLAY;
`endif
      end
      GAMEOVER: begin
        if (startOfFrame && hold_reg != 10'd0)
          hold_next = hold_reg - 10'd1;
        // Presses during the hold are dropped, not remembered.
        if (start_edge && hold_reg == 10'd0)
          state_next = WELCOME;
      end
      default: state_next = WELCOME;
    endcase
  end

  assign selector    = (state_reg == GAMEOVER) ? 2'd2 :
                       (state_reg == WELCOME)  ? 2'd0 : 2'd1;
  assign gameRunning = (state_reg == PLAY);
  assign lives       = lives_reg;
  assign newGame     = new_game_reg;

endmodule
